uart_rx_sched: RTL and testbench

UART_RX_SCHED -- requirements
Module: uart_rx_sched

---
 rtl/uart_rx_sched_pkg.sv | 11 +
 rtl/uart_rx_sched_if.sv | 25 ++
 rtl/uart_rx_sched_rrarb.sv | 18 +
 rtl/uart_rx_sched.sv | 71 +++++++
 tb/tb_uart_rx_sched.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_sched_pkg.sv
// uart_rx_sched_pkg: FSM state encodings, threshold constants and threshold lookup
package uart_rx_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, DATA = 2'd2} state_t;
    localparam logic [4:0] THR_1 = 5'd1;
    localparam logic [4:0] THR_4 = 5'd4;
    localparam logic [4:0] THR_8 = 5'd8;
    localparam logic [4:0] THR_14 = 5'd14;
    function automatic logic [4:0] thr_of(input logic [1:0] lvl);
        return lvl == 2'b00 ? THR_1 : lvl == 2'b01 ? THR_4 : lvl == 2'b10 ? THR_8 : THR_14;
    endfunction
endpackage

// File: rtl/uart_rx_sched_if.sv
// uart_rx_sched_if: receive-FIFO, requester and interrupt signals of the scheduler
//   master: scheduler side (drives fifo_pop, gnt, rd_data, rd_valid, thr_irq, to_irq)
//   slave:  FIFO/requester/baud side (drives fifo_count, fifo_data, fifo_push, req, trig_lvl, char_tick)
interface uart_rx_sched_if #(parameter int CNT_W = 5);
    logic [CNT_W-1:0] fifo_count;
    logic [10:0] fifo_data;
    logic fifo_push;
    logic fifo_pop;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [7:0] rd_data;
    logic rd_valid;
    logic [1:0] trig_lvl;
    logic char_tick;
    logic thr_irq;
    logic to_irq;
    modport master (
        input fifo_count, fifo_data, fifo_push, req, trig_lvl, char_tick,
        output fifo_pop, gnt, rd_data, rd_valid, thr_irq, to_irq
    );
    modport slave (
        output fifo_count, fifo_data, fifo_push, req, trig_lvl, char_tick,
        input fifo_pop, gnt, rd_data, rd_valid, thr_irq, to_irq
    );
endinterface

// File: rtl/uart_rx_sched_rrarb.sv
// uart_rx_rrarb: two-requester round-robin arbiter with one-hot grant
//   clk, rst: clock and sync active-high reset
//   req: request levels; gnt: one-hot combinational winner
//   adv: advance the pointer away from last_id (index of the requester just served)
module uart_rx_rrarb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       last_id,
    output logic [1:0] gnt
);
    logic ptr;
    always_ff @(posedge clk)
        if (rst) ptr <= 1'b0;
        else if (adv) ptr <= ~last_id;
    always_comb gnt = req == 2'b11 ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/uart_rx_sched.sv
// uart_rx_sched: receive-FIFO read scheduler with round-robin grant, threshold and timeout interrupts
//   clk, rst: clock and sync active-high reset
//   bus (uart_rx_sched_if.master): FIFO pop/data, req/gnt/rd_data/rd_valid, trig_lvl, char_tick, thr_irq, to_irq
//   Define UART_RX_TIMEOUT_EN to build the receive-timeout counter; otherwise to_irq is tied low.
module uart_rx_sched
    import uart_rx_sched_pkg::*;
#(
    parameter int CNT_W = 5,
    parameter int TO_CHARS = 4
) (
    input logic clk,
    input logic rst,
    uart_rx_sched_if.master bus
);
    state_t state;
    logic [1:0] win, arb_gnt, gnt_q;
    logic pop_q, valid_q;
    uart_rx_rrarb u_arb (
        .clk(clk),
        .rst(rst),
        .req(bus.req),
        .adv(state == DATA),
        .last_id(win[1]),
        .gnt(arb_gnt)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            win <= 2'b00;
            gnt_q <= 2'b00;
            pop_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.fifo_count && |bus.req) begin
                    state <= POP;
                    win <= arb_gnt;
                    pop_q <= 1'b1;
                end
                POP: begin
                    state <= DATA;
                    pop_q <= 1'b0;
                    valid_q <= 1'b1;
                    gnt_q <= win;
                end
                default: begin
                    state <= IDLE;
                    valid_q <= 1'b0;
                    gnt_q <= 2'b00;
                end
            endcase
        end
    // Outputs are forced low during reset so a transaction caught by reset never completes
    assign bus.fifo_pop = pop_q & ~rst;
    assign bus.rd_valid = valid_q & ~rst;
    assign bus.gnt = rst ? 2'b00 : gnt_q;
    // FIFO word arrives the cycle after the pop, i.e. while in DATA
    assign bus.rd_data = (valid_q && !rst) ? bus.fifo_data[10:3] : 8'h00;
    // Smallest threshold is 1, so an empty FIFO never raises thr_irq
    assign bus.thr_irq = 32'(bus.fifo_count) >= 32'(thr_of(bus.trig_lvl));
`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TO_CHARS + 1);
    logic [TW-1:0] to_cnt;
    always_ff @(posedge clk)
        if (rst || bus.fifo_push || pop_q || !(|bus.fifo_count)) to_cnt <= '0;
        else if (bus.char_tick && to_cnt != TW'(TO_CHARS)) to_cnt <= to_cnt + 1'b1;
    assign bus.to_irq = !rst && to_cnt == TW'(TO_CHARS);
`else
    assign bus.to_irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_sched.sv
// tb_uart_rx_sched: self-checking bench with a FIFO model and grant/byte scoreboard
module tb_uart_rx_sched;
    localparam int CNT_W = 5;
`ifdef UART_RX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [10:0] fq[$];
    logic [7:0] dq[$];
    logic [1:0] gq[$];
    logic [10:0] push_w = '0;

    uart_rx_sched_if #(.CNT_W(CNT_W)) bus ();
    uart_rx_sched #(.CNT_W(CNT_W), .TO_CHARS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // One clock: FIFO model follows the strobes seen before the edge, then outputs are scored
    task automatic step();
        logic s_pop, s_push, s_rst;
        logic [CNT_W-1:0] s_cnt;
        logic [1:0] eg;
        logic [7:0] ed;
        s_pop = bus.fifo_pop;
        s_push = bus.fifo_push;
        s_rst = rst;
        s_cnt = bus.fifo_count;
        @(posedge clk);
        @(negedge clk);
        if (s_rst) begin
            fq.delete();
            bus.fifo_data = '0;
        end else begin
            if (s_push) fq.push_back(push_w);
            if (s_pop && fq.size() != 0) bus.fifo_data = fq.pop_front();
        end
        bus.fifo_count = CNT_W'(fq.size());
        #1;
        if (!rst) begin
            checks++;
            if (s_pop && s_cnt == 0) begin
                failures++;
                $display("FAIL pop_when_empty fifo_pop=%b count=%0d expected no pop", s_pop, s_cnt);
            end
            if (!bus.rd_valid && bus.gnt != 2'b00) begin
                failures++;
                $display("FAIL gnt_without_valid gnt=%b expected 00", bus.gnt);
            end
            if (bus.rd_valid) begin
                checks++;
                if (gq.size() == 0 || dq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rd_valid gnt=%b data=%h expected none", bus.gnt, bus.rd_data);
                end else begin
                    eg = gq.pop_front();
                    ed = dq.pop_front();
                    if (bus.gnt !== eg || bus.rd_data !== ed) begin
                        failures++;
                        $display("FAIL scoreboard gnt=%b data=%h expected gnt=%b data=%h", bus.gnt, bus.rd_data, eg, ed);
                    end
                end
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_w = {b, 3'($urandom_range(0, 7))};
        bus.fifo_push = 1'b1;
        dq.push_back(b);
        step();
        bus.fifo_push = 1'b0;
    endtask

    task automatic do_reset();
        checks++;
        if (gq.size() != 0) begin
            failures++;
            $display("FAIL pending_grants left=%0d expected 0", gq.size());
        end
        bus.req = 2'b00;
        bus.char_tick = 1'b0;
        bus.fifo_push = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        dq.delete();
        gq.delete();
        step();
    endtask

    task automatic test_reset();
        bus.req = 2'b11;
        bus.char_tick = 1'b1;
        rst = 1'b1;
        step();
        step();
        checks += 5;
        if (bus.fifo_pop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b exp=0", bus.fifo_pop); end
        if (bus.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); end
        if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.rd_data); end
        if (bus.to_irq !== 1'b0) begin failures++; $display("FAIL reset_to_irq got=%b exp=0", bus.to_irq); end
        rst = 1'b0;
        bus.req = 2'b00;
        bus.char_tick = 1'b0;
        step();
        checks++;
        if (bus.thr_irq !== 1'b0) begin failures++; $display("FAIL empty_thr got=%b exp=0", bus.thr_irq); end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
        bus.req = 2'b01;
        gq.push_back(2'b01);
        step();
        checks++;
        if (bus.fifo_pop !== 1'b1 || bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_t1 pop=%b valid=%b exp pop=1 valid=0", bus.fifo_pop, bus.rd_valid);
        end
        bus.req = 2'b00;
        step();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.fifo_pop !== 1'b0) begin
            failures++;
            $display("FAIL single_t2 valid=%b pop=%b exp valid=1 pop=0", bus.rd_valid, bus.fifo_pop);
        end
        step();
        step();
        checks++;
        if (bus.fifo_pop !== 1'b0 || bus.fifo_count !== CNT_W'(2)) begin
            failures++;
            $display("FAIL single_idle pop=%b count=%0d exp pop=0 count=2", bus.fifo_pop, bus.fifo_count);
        end
    endtask

    task automatic test_contention();
        int n, pops, first, last;
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(0, 255)));
        bus.req = 2'b11;
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        n = 0;
        pops = 0;
        first = 0;
        last = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            step();
            if (bus.fifo_pop) pops++;
            if (bus.rd_valid) begin
                if (n == 0) first = c;
                last = c;
                n++;
                if (n == 4) bus.req = 2'b00;
            end
        end
        step();
        step();
        checks += 4;
        if (n != 4) begin failures++; $display("FAIL contention_grants got=%0d exp=4", n); end
        if (pops != 4) begin failures++; $display("FAIL contention_pops got=%0d exp=4", pops); end
        if (last - first != 9) begin failures++; $display("FAIL contention_rate span=%0d exp=9", last - first); end
        if (bus.fifo_count !== CNT_W'(12)) begin failures++; $display("FAIL contention_count got=%0d exp=12", bus.fifo_count); end
    endtask

    task automatic test_empty();
        int pops;
        do_reset();
        bus.req = 2'b10;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.fifo_pop) pops++;
        end
        checks++;
        if (pops != 0) begin failures++; $display("FAIL empty_pops got=%0d exp=0", pops); end
        gq.push_back(2'b10);
        push_byte(8'hA5);
        step();
        checks++;
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL empty_early valid=%b exp=0", bus.rd_valid); end
        bus.req = 2'b00;
        step();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.gnt !== 2'b10) begin
            failures++;
            $display("FAIL empty_grant valid=%b gnt=%b exp valid=1 gnt=10", bus.rd_valid, bus.gnt);
        end
        step();
    endtask

    task automatic test_threshold();
        do_reset();
        bus.trig_lvl = 2'b10;
        for (int i = 0; i < 7; i++) push_byte(8'($urandom_range(0, 255)));
        checks++;
        if (bus.thr_irq !== 1'b0) begin failures++; $display("FAIL thr_at7 got=%b exp=0", bus.thr_irq); end
        push_byte(8'h3C);
        checks++;
        if (bus.thr_irq !== 1'b1) begin failures++; $display("FAIL thr_at8 got=%b exp=1", bus.thr_irq); end
        bus.trig_lvl = 2'b11;
        #1;
        checks++;
        if (bus.thr_irq !== 1'b0) begin failures++; $display("FAIL thr14_at8 got=%b exp=0", bus.thr_irq); end
        bus.trig_lvl = 2'b01;
        #1;
        checks++;
        if (bus.thr_irq !== 1'b1) begin failures++; $display("FAIL thr4_at8 got=%b exp=1", bus.thr_irq); end
        bus.trig_lvl = 2'b10;
        bus.req = 2'b01;
        gq.push_back(2'b01);
        step();
        bus.req = 2'b00;
        step();
        checks++;
        if (bus.thr_irq !== 1'b0) begin failures++; $display("FAIL thr_after_pop got=%b exp=0", bus.thr_irq); end
        step();
        bus.trig_lvl = 2'b00;
    endtask

    task automatic test_timeout();
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        for (int i = 0; i < 4; i++) begin
            bus.char_tick = 1'b1;
            step();
            if (i == 2) begin
                checks++;
                if (bus.to_irq !== 1'b0) begin failures++; $display("FAIL to_3ticks got=%b exp=0", bus.to_irq); end
            end
        end
        bus.char_tick = 1'b0;
        checks++;
        if (bus.to_irq !== TO_EN) begin failures++; $display("FAIL to_4ticks got=%b exp=%b", bus.to_irq, TO_EN); end
        bus.char_tick = 1'b1;
        step();
        checks++;
        if (bus.to_irq !== TO_EN) begin failures++; $display("FAIL to_saturate got=%b exp=%b", bus.to_irq, TO_EN); end
        push_byte(8'h33);
        bus.char_tick = 1'b0;
        checks++;
        if (bus.to_irq !== 1'b0) begin failures++; $display("FAIL to_push_vs_tick got=%b exp=0", bus.to_irq); end
        bus.char_tick = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.char_tick = 1'b0;
        bus.req = 2'b01;
        gq.push_back(2'b01);
        step();
        checks++;
        if (bus.to_irq !== TO_EN) begin failures++; $display("FAIL to_in_pop got=%b exp=%b", bus.to_irq, TO_EN); end
        bus.req = 2'b00;
        step();
        checks++;
        if (bus.to_irq !== 1'b0) begin failures++; $display("FAIL to_after_pop got=%b exp=0", bus.to_irq); end
        step();
    endtask

    task automatic test_reset_in_pop();
        do_reset();
        push_byte(8'h5A);
        push_byte(8'hC3);
        bus.req = 2'b01;
        gq.push_back(2'b01);
        step();
        bus.req = 2'b00;
        step();
        step();
        bus.req = 2'b10;
        step();
        checks++;
        if (bus.fifo_pop !== 1'b1) begin failures++; $display("FAIL rip_pop got=%b exp=1", bus.fifo_pop); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.fifo_pop !== 1'b0 || bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rip_hold pop=%b valid=%b exp 0 0", bus.fifo_pop, bus.rd_valid);
        end
        step();
        rst = 1'b0;
        bus.req = 2'b00;
        dq.delete();
        gq.delete();
        step();
        checks++;
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rip_no_valid got=%b exp=0", bus.rd_valid); end
        push_byte(8'h77);
        bus.req = 2'b11;
        gq.push_back(2'b01);
        step();
        bus.req = 2'b00;
        step();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.gnt !== 2'b01) begin
            failures++;
            $display("FAIL rip_next_grant valid=%b gnt=%b exp valid=1 gnt=01", bus.rd_valid, bus.gnt);
        end
        step();
    endtask

    initial begin
        bus.fifo_count = '0;
        bus.fifo_data = '0;
        bus.fifo_push = 1'b0;
        bus.req = 2'b00;
        bus.trig_lvl = 2'b00;
        bus.char_tick = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_empty();
        test_threshold();
        test_timeout();
        test_reset_in_pop();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
